// File: rtl/ccff_config_loader.sv
// Configuration-chain loader: byte stream in, MSB-first serial bits plus divided prog_clk out.
// Define CCFF_CRC_CHECK_EN to add a trailing CRC-8 byte check before the fabric is released.
module ccff_config_loader #(
  parameter int unsigned CHAIN_LEN = 512,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       prog_clk,
  output logic       ccff_head,
  output logic       fabric_rst_n,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned DIV_W = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CHAIN_LEN);

  typedef enum logic [2:0] {
    IDLE, FETCH, SHIFT_LO, SHIFT_HI, FINISH
`ifdef CCFF_CRC_CHECK_EN
    , CHECK
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             ready_d, pclk_d, head_d, frst_d, busy_d, done_d;

`ifdef CCFF_CRC_CHECK_EN
  logic [7:0] crc_q, crc_d, crc_next;
  logic       err_d;
  logic       crc_fb;

  // Serial CRC-8, poly 0x07, fed with the bit leaving the shift register.
  always_comb begin
    crc_fb   = crc_q[7] ^ shreg_q[7];
    crc_next = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      div_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      byte_ready   <= 1'b0;
      prog_clk     <= 1'b0;
      ccff_head    <= 1'b0;
      fabric_rst_n <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef CCFF_CRC_CHECK_EN
      crc_q        <= '0;
      error        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      div_q        <= div_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      byte_ready   <= ready_d;
      prog_clk     <= pclk_d;
      ccff_head    <= head_d;
      fabric_rst_n <= frst_d;
      busy         <= busy_d;
      done         <= done_d;
`ifdef CCFF_CRC_CHECK_EN
      crc_q        <= crc_d;
      error        <= err_d;
`endif
    end
  end

`ifndef CCFF_CRC_CHECK_EN
  assign error = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    head_d    = ccff_head;
    frst_d    = fabric_rst_n;
    busy_d    = busy;
    done_d    = done;
`ifdef CCFF_CRC_CHECK_EN
    crc_d     = crc_q;
    err_d     = error;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          frst_d    = 1'b0;
          bit_cnt_d = '0;
          bit_idx_d = '0;
`ifdef CCFF_CRC_CHECK_EN
          err_d     = 1'b0;
          crc_d     = '0;
`endif
        end
      end
      FETCH: begin
        if (byte_valid && byte_ready) begin
          shreg_d = byte_data;
          head_d  = byte_data[7];
          div_d   = '0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_q == DIV_LAST) begin
          div_d     = '0;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          bit_idx_d = bit_idx_q + 3'd1;
          shreg_d   = {shreg_q[6:0], 1'b0};
`ifdef CCFF_CRC_CHECK_EN
          crc_d     = crc_next;
`endif
          // Chain length wins over byte boundary so a partial last byte is dropped.
          if (bit_cnt_d == BIT_LAST) begin
            head_d = 1'b0;
`ifdef CCFF_CRC_CHECK_EN
            state_d = CHECK;
`else
            state_d = FINISH;
`endif
          end else if (bit_idx_q == 3'd7) begin
            state_d = FETCH;
          end else begin
            head_d  = shreg_q[6];
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
`ifdef CCFF_CRC_CHECK_EN
      CHECK: begin
        if (byte_valid && byte_ready) begin
          if (byte_data == crc_q) begin
            state_d = FINISH;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
`endif
      FINISH: begin
        head_d  = 1'b0;
        frst_d  = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == FETCH);
`ifdef CCFF_CRC_CHECK_EN
    if (state_d == CHECK) ready_d = 1'b1;
`endif
    pclk_d = (state_d == SHIFT_HI);
  end

endmodule

// File: tb/tb_ccff_config_loader.sv
// Directed bench: an 8-bit/CLK_DIV=1 loader and a 12-bit/CLK_DIV=2 loader share one clock and reset.
module tb_ccff_config_loader;

`ifdef CCFF_CRC_CHECK_EN
  localparam int CRC_ON = 1;
`else
  localparam int CRC_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, valid_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       byte_ready_a, prog_clk_a, ccff_head_a, fabric_rst_n_a, busy_a, done_a, error_a;
  logic       start_b = 1'b0, valid_b = 1'b0;
  logic [7:0] data_b = 8'h00;
  logic       byte_ready_b, prog_clk_b, ccff_head_b, fabric_rst_n_b, busy_b, done_b, error_b;

  ccff_config_loader #(.CHAIN_LEN(8), .CLK_DIV(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .byte_data(data_a), .byte_valid(valid_a),
    .byte_ready(byte_ready_a), .prog_clk(prog_clk_a), .ccff_head(ccff_head_a),
    .fabric_rst_n(fabric_rst_n_a), .busy(busy_a), .done(done_a), .error(error_a)
  );

  ccff_config_loader #(.CHAIN_LEN(12), .CLK_DIV(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .byte_data(data_b), .byte_valid(valid_b),
    .byte_ready(byte_ready_b), .prog_clk(prog_clk_b), .ccff_head(ccff_head_b),
    .fabric_rst_n(fabric_rst_n_b), .busy(busy_b), .done(done_b), .error(error_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses_a = 0, pulses_b = 0, acc_a = 0, acc_b = 0;
  int good_sp_a = 0, last_rise_a = 0, viol = 0;
  logic [15:0] bits_a = '0, bits_b = '0;

  always @(posedge clk) begin
    cyc++;
    if (valid_a && byte_ready_a) acc_a++;
    if (valid_b && byte_ready_b) acc_b++;
  end

  // Chain model: capture ccff_head on every prog_clk rising edge.
  always @(posedge prog_clk_a) begin
    bits_a = {bits_a[14:0], ccff_head_a};
    pulses_a++;
    if (cyc - last_rise_a == 2) good_sp_a++;
    last_rise_a = cyc;
    if (fabric_rst_n_a) viol++;
  end

  always @(posedge prog_clk_b) begin
    bits_b = {bits_b[14:0], ccff_head_b};
    pulses_b++;
    if (fabric_rst_n_b) viol++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1; tick(1); start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1; tick(1); start_b = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] d);
    data_a = d; valid_a = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (byte_ready_a) begin tick(1); break; end
      tick(1);
    end
    valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    data_b = d; valid_b = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (byte_ready_b) begin tick(1); break; end
      tick(1);
    end
    valid_b = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int n = 0; n < 400; n++) begin
      if (done_a) break;
      tick(1);
    end
  endtask

  task automatic wait_done_b();
    for (int n = 0; n < 400; n++) begin
      if (done_b) break;
      tick(1);
    end
  endtask

  task automatic wait_ready_b();
    for (int n = 0; n < 400; n++) begin
      if (byte_ready_b) break;
      tick(1);
    end
  endtask

  // Full 12-bit pass on B with bytes 0xF0, 0xC3 (plus CRC 0xE7 when enabled).
  task automatic pass_b();
    pulse_start_b();
    send_b(8'hF0);
    send_b(8'hC3);
`ifdef CCFF_CRC_CHECK_EN
    send_b(8'hE7);
`endif
    wait_done_b();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({byte_ready_a, prog_clk_a, ccff_head_a, fabric_rst_n_a, busy_a, done_a, error_a} !== 7'b0) begin
      errors++;
      $display("FAIL reset_a: got %b want 0000000",
               {byte_ready_a, prog_clk_a, ccff_head_a, fabric_rst_n_a, busy_a, done_a, error_a});
    end
    checks++;
    if ({byte_ready_b, prog_clk_b, ccff_head_b, fabric_rst_n_b, busy_b, done_b, error_b} !== 7'b0) begin
      errors++;
      $display("FAIL reset_b: got %b want 0000000",
               {byte_ready_b, prog_clk_b, ccff_head_b, fabric_rst_n_b, busy_b, done_b, error_b});
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single_byte();
    int p0, a0, s0;
    p0 = pulses_a; a0 = acc_a; s0 = good_sp_a;
    pulse_start_a();
    checks++;
    if ({busy_a, byte_ready_a} !== 2'b11) begin
      errors++; $display("FAIL single_fetch: busy,ready got %b want 11", {busy_a, byte_ready_a});
    end
    send_a(8'hA5);
`ifdef CCFF_CRC_CHECK_EN
    send_a(8'h72);
`endif
    wait_done_a();
    checks++;
    if (bits_a[7:0] !== 8'hA5) begin
      errors++; $display("FAIL single_bits: got %h want a5", bits_a[7:0]);
    end
    checks++;
    if (pulses_a - p0 !== 8) begin
      errors++; $display("FAIL single_pulses: got %0d want 8", pulses_a - p0);
    end
    checks++;
    if (good_sp_a - s0 !== 7) begin
      errors++; $display("FAIL single_spacing: 2-cycle gaps got %0d want 7", good_sp_a - s0);
    end
    checks++;
    if (acc_a - a0 !== 1 + CRC_ON) begin
      errors++; $display("FAIL single_bytes: got %0d want %0d", acc_a - a0, 1 + CRC_ON);
    end
    checks++;
    if ({done_a, fabric_rst_n_a, busy_a, error_a, ccff_head_a} !== 5'b11000) begin
      errors++; $display("FAIL single_status: done,frst,busy,err,head got %b want 11000",
                         {done_a, fabric_rst_n_a, busy_a, error_a, ccff_head_a});
    end
  endtask

  task automatic test_partial_byte();
    int p0, a0;
    p0 = pulses_b; a0 = acc_b;
    pulse_start_b();
    send_b(8'hF0);
    send_b(8'hC3);
    for (int n = 0; n < 400; n++) begin
      if (done_b || byte_ready_b) break;
      tick(1);
    end
    checks++;
    if (byte_ready_b !== 1'(CRC_ON)) begin
      errors++; $display("FAIL partial_no_req: byte_ready got %b want %0d", byte_ready_b, CRC_ON);
    end
    checks++;
    if (pulses_b - p0 !== 12) begin
      errors++; $display("FAIL partial_pulses: got %0d want 12", pulses_b - p0);
    end
`ifdef CCFF_CRC_CHECK_EN
    send_b(8'hE7);
    wait_done_b();
`endif
    checks++;
    if (bits_b[11:0] !== 12'hF0C) begin
      errors++; $display("FAIL partial_bits: got %h want f0c", bits_b[11:0]);
    end
    checks++;
    if (acc_b - a0 !== 2 + CRC_ON) begin
      errors++; $display("FAIL partial_bytes: got %0d want %0d", acc_b - a0, 2 + CRC_ON);
    end
    checks++;
    if ({done_b, fabric_rst_n_b, busy_b, error_b} !== 4'b1100) begin
      errors++; $display("FAIL partial_status: done,frst,busy,err got %b want 1100",
                         {done_b, fabric_rst_n_b, busy_b, error_b});
    end
  endtask

  task automatic test_stall_gap();
    int p0, hi;
    p0 = pulses_b; hi = 0;
    pulse_start_b();
    send_b(8'hF0);
    wait_ready_b();
    checks++;
    if (pulses_b - p0 !== 8) begin
      errors++; $display("FAIL gap_first_byte: pulses got %0d want 8", pulses_b - p0);
    end
    repeat (20) begin
      if (prog_clk_b !== 1'b0) hi++;
      tick(1);
    end
    checks++;
    if (hi !== 0 || pulses_b - p0 !== 8) begin
      errors++; $display("FAIL gap_quiet: high cycles %0d pulses %0d want 0 and 8", hi, pulses_b - p0);
    end
    send_b(8'hC3);
`ifdef CCFF_CRC_CHECK_EN
    send_b(8'hE7);
`endif
    wait_done_b();
    checks++;
    if (pulses_b - p0 !== 12 || bits_b[11:0] !== 12'hF0C) begin
      errors++; $display("FAIL gap_total: pulses %0d bits %h want 12 f0c", pulses_b - p0, bits_b[11:0]);
    end
  endtask

  task automatic test_reset_mid_pass();
    int p0;
    p0 = pulses_b;
    pulse_start_b();
    send_b(8'hF0);
    for (int n = 0; n < 200; n++) begin
      if (pulses_b - p0 >= 5) break;
      tick(1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready_b, prog_clk_b, ccff_head_b, fabric_rst_n_b, busy_b, done_b, error_b} !== 7'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b want 0000000",
               {byte_ready_b, prog_clk_b, ccff_head_b, fabric_rst_n_b, busy_b, done_b, error_b});
    end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    p0 = pulses_b;
    pass_b();
    checks++;
    if (pulses_b - p0 !== 12 || bits_b[11:0] !== 12'hF0C || done_b !== 1'b1) begin
      errors++; $display("FAIL midreset_reload: pulses %0d bits %h done %b want 12 f0c 1",
                         pulses_b - p0, bits_b[11:0], done_b);
    end
  endtask

  task automatic test_start_while_busy();
    int p0;
    p0 = pulses_b;
    pulse_start_b();
    send_b(8'hF0);
    tick(3);
    pulse_start_b();
    send_b(8'hC3);
    pulse_start_b();
`ifdef CCFF_CRC_CHECK_EN
    send_b(8'hE7);
`endif
    wait_done_b();
    checks++;
    if (pulses_b - p0 !== 12 || bits_b[11:0] !== 12'hF0C) begin
      errors++; $display("FAIL busy_start: pulses %0d bits %h want 12 f0c", pulses_b - p0, bits_b[11:0]);
    end
    checks++;
    if ({done_b, busy_b, fabric_rst_n_b} !== 3'b101) begin
      errors++; $display("FAIL busy_status: done,busy,frst got %b want 101", {done_b, busy_b, fabric_rst_n_b});
    end
  endtask

  task automatic test_idle_quiet();
    int p0;
    p0 = pulses_b;
    tick(10);
    checks++;
    if (pulses_b !== p0 || {done_b, fabric_rst_n_b} !== 2'b11) begin
      errors++; $display("FAIL idle_hold: extra pulses %0d done,frst %b want 0 11",
                         pulses_b - p0, {done_b, fabric_rst_n_b});
    end
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL pulse_while_released: got %0d want 0", viol);
    end
  endtask

`ifdef CCFF_CRC_CHECK_EN
  task automatic test_crc();
    pulse_start_a();
    send_a(8'h01);
    send_a(8'h07);
    wait_done_a();
    checks++;
    if ({done_a, error_a, fabric_rst_n_a} !== 3'b101) begin
      errors++; $display("FAIL crc_match: done,err,frst got %b want 101", {done_a, error_a, fabric_rst_n_a});
    end
    pulse_start_a();
    send_a(8'h01);
    send_a(8'h00);
    wait_done_a();
    checks++;
    if ({done_a, error_a, fabric_rst_n_a, busy_a} !== 4'b1100) begin
      errors++; $display("FAIL crc_mismatch: done,err,frst,busy got %b want 1100",
                         {done_a, error_a, fabric_rst_n_a, busy_a});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_partial_byte();
    test_stall_gap();
    test_reset_mid_pass();
    test_start_while_busy();
    test_idle_quiet();
`ifdef CCFF_CRC_CHECK_EN
    test_crc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
